fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Program-counter sequencer that drives the instruction ROM's `PrgCtr` address and owns the fetch state of the core. It starts a program on a `Start` pulse and advances sequentially. It applies absolute or PC-relative branches and honours decode stalls. It stops on a halt instruction and reports completion to the test harness through `Done`.

## Interface
Parameters:
- `D`, 12, program-counter and ROM address width; ROM depth is 2**D.
- `START_ADDR`, 0, first fetch address after `Start`.
- `STK_DEPTH`, 4, return-stack entries; used only with `FETCH_CTRL_RET_STACK_EN`.

Ports:
- `Clk`  in  1  single clock, rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `Start`  in  1  begin or restart a program; sampled in IDLE or DONE.
- `Stall`  in  1  hold current `PrgCtr`; no instruction is consumed.
- `Halt`  in  1  current instruction is a halt; from decode.
- `BrTaken`  in  1  current instruction redirects fetch.
- `BrRel`  in  1  1 = target is `PrgCtr + BrTarget`; 0 = target is `BrTarget`.
- `BrTarget`  in  D  absolute address, or two's-complement offset.
- `Call`  in  1  branch that pushes the return address.
- `Ret`  in  1  pop the return address into `PrgCtr`.
- `PrgCtr`  out  D  registered ROM address.
- `InstValid`  out  1  ROM output at `PrgCtr` is consumed this cycle.
- `Busy`  out  1  state is RUN.
- `Done`  out  1  program halted; held until restart.
- `StackErr`  out  1  sticky return-stack overflow/underflow flag.

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN on `Start`; `PrgCtr` <= `START_ADDR`.
- DONE -> RUN on `Start`:
  - `PrgCtr` <= `START_ADDR`, `Done` <= 0.
  - Stack pointer cleared; `StackErr` cleared.
- `InstValid` = (state == RUN) && !`Stall`, combinational.
- `Halt`, `BrTaken`, `Call` and `Ret` are ignored unless `InstValid`.
- RUN next-PC priority (highest first):
  1. `Stall`: hold `PrgCtr`.
  2. `Halt`: go to DONE; `PrgCtr` holds the halt address.
  3. `Ret` (macro on only): `PrgCtr` <= top of stack, pop.
  4. `BrTaken` or `Call`: `PrgCtr` <= target. A `Call` also pushes `PrgCtr+1` (macro on only).
  5. Otherwise: `PrgCtr` <= `PrgCtr+1`.
- Arithmetic is modulo 2**D:
  - `2**D-1` + 1 wraps to 0.
  - Relative targets wrap both directions; `BrTarget` is sign-interpreted in D bits.
- `Start` while in RUN is ignored.
- Reset values: state IDLE, `PrgCtr` = `START_ADDR`, `Busy` = 0, `Done` = 0, `InstValid` = 0, `StackErr` = 0, stack empty.
- Reset mid-program aborts immediately; no completion is reported.

## Timing
- `PrgCtr` is registered. The ROM is combinational, so the instruction is valid in the same cycle as its address.
- Decode outputs are combinational from the instruction and take effect at the next edge.
- Throughput is one instruction per non-stalled RUN cycle.
- Taken branches and calls have zero bubbles.
- `Start` high at edge N:
  - `Busy` and `InstValid` go high after edge N.
  - The first instruction, at `START_ADDR`, is consumed in cycle N+1.
- `Halt` with `InstValid` at edge M: `Done` goes high and `Busy` goes low after edge M. `PrgCtr` is frozen.
- `Stall` may be held for any number of cycles; `PrgCtr` stays bit-stable throughout.

## Configuration
- `FETCH_CTRL_RET_STACK_EN` defined:
  - Adds a `STK_DEPTH`-entry return-address stack; `Call` pushes and `Ret` pops.
  - Push when full: push is discarded, jump still taken, `StackErr` <= 1.
  - Pop when empty: `PrgCtr` <= `PrgCtr+1`, `StackErr` <= 1.
  - Simultaneous `Call` and `Ret`: `Ret` wins; no push occurs.
- Macro undefined:
  - No stack storage is built.
  - `Call` behaves as a plain `BrTaken`; `Ret` is ignored and falls through to increment.
  - `StackErr` is tied 0.

## Test plan
- Reset, then `Start` pulse with no branches: `PrgCtr` steps 0,1,2,3. `Halt` asserted at address 3 gives `Done` = 1 and `PrgCtr` holding 3.
- `BrTaken` = 1, `BrRel` = 0, `BrTarget` = 0x100 at address 5: next `PrgCtr` = 0x100. Then `BrRel` = 1, `BrTarget` = 0xFFE at 0x100: next `PrgCtr` = 0x0FE.
- `Stall` held 3 cycles at address 7: `PrgCtr` stays 7, `InstValid` = 0, and a concurrent `Halt` is ignored; then `PrgCtr` = 8.
- `PrgCtr` = 0xFFF, no branch: next `PrgCtr` = 0x000. Relative offset +2 from 0xFFF gives 0x001.
- Macro on: `Call` to 0x200 from 0x010, then `Ret` gives `PrgCtr` 0x011. Five nested calls give `StackErr` = 1. `Ret` on an empty stack after restart gives PC+1 and `StackErr` = 1.
- `Rst_n` low for one cycle mid-RUN at address 0x40: outputs return to their reset values immediately. A later `Start` resumes from 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Program-counter sequencer: start/run/halt control, branches, calls and decode stalls.
// Optional return-address stack is enabled by defining FETCH_CTRL_RET_STACK_EN.
module fetch_ctrl #(
  parameter int unsigned    D          = 12,
  parameter logic [D-1:0]   START_ADDR = '0,
  parameter int unsigned    STK_DEPTH  = 4
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         Start,
  input  logic         Stall,
  input  logic         Halt,
  input  logic         BrTaken,
  input  logic         BrRel,
  input  logic [D-1:0] BrTarget,
  input  logic         Call,
  input  logic         Ret,
  output logic [D-1:0] PrgCtr,
  output logic         InstValid,
  output logic         Busy,
  output logic         Done,
  output logic         StackErr
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [D-1:0] PC_ONE = D'(1);

  state_e       state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic [D-1:0] pc_inc, br_tgt;

  // Relative targets rely on D-bit wraparound to give signed offsets.
  assign pc_inc = pc_q + PC_ONE;
  assign br_tgt = BrRel ? (pc_q + BrTarget) : BrTarget;

  assign PrgCtr    = pc_q;
  assign Busy      = (state_q == RUN);
  assign Done      = (state_q == DONE);
  assign InstValid = (state_q == RUN) && !Stall;

`ifdef FETCH_CTRL_RET_STACK_EN
  localparam int unsigned SPW = $clog2(STK_DEPTH + 1);

  logic [D-1:0]   stk_q [STK_DEPTH];
  logic [D-1:0]   stk_d [STK_DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic [D-1:0]   stk_top;

  always_comb begin
    stk_top = '0;
    for (int unsigned i = 0; i < STK_DEPTH; i++) begin
      if (sp_q == SPW'(i + 1)) stk_top = stk_q[i];
    end
  end

  assign StackErr = err_q;
`else
  logic unused_ok;
  assign unused_ok = Ret ^ (STK_DEPTH == 0);
  assign StackErr  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef FETCH_CTRL_RET_STACK_EN
    stk_d   = stk_q;
    sp_d    = sp_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = START_ADDR;
`ifdef FETCH_CTRL_RET_STACK_EN
          sp_d    = '0;
          err_d   = 1'b0;
`endif
        end
      end
      RUN: begin
        if (!Stall) begin
`ifdef FETCH_CTRL_RET_STACK_EN
          if (Halt) begin
            state_d = DONE;
          end else if (Ret) begin
            if (sp_q == '0) begin
              pc_d  = pc_inc;
              err_d = 1'b1;
            end else begin
              pc_d = stk_top;
              sp_d = sp_q - SPW'(1);
            end
          end else if (BrTaken || Call) begin
            pc_d = br_tgt;
            if (Call) begin
              if (sp_q == SPW'(STK_DEPTH)) begin
                err_d = 1'b1;
              end else begin
                for (int unsigned i = 0; i < STK_DEPTH; i++) begin
                  if (sp_q == SPW'(i)) stk_d[i] = pc_inc;
                end
                sp_d = sp_q + SPW'(1);
              end
            end
          end else begin
            pc_d = pc_inc;
          end
`else
          if (Halt) begin
            state_d = DONE;
          end else if (BrTaken || Call) begin
            pc_d = br_tgt;
          end else begin
            pc_d = pc_inc;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
`ifdef FETCH_CTRL_RET_STACK_EN
      sp_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef FETCH_CTRL_RET_STACK_EN
      sp_q    <= sp_d;
      err_q   <= err_d;
`endif
    end
  end

`ifdef FETCH_CTRL_RET_STACK_EN
  // Entries above the stack pointer are never read, so storage needs no reset.
  always_ff @(posedge Clk) begin
    stk_q <= stk_d;
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: queue-based reference model compared every cycle,
// plus hand-computed expectations at key points of the program.
module tb_fetch_ctrl;
  localparam int unsigned D     = 12;
  localparam int unsigned STK   = 4;
  localparam int          DEPTH = 1 << D;

  logic         Clk = 1'b0;
  logic         Rst_n, Start, Stall, Halt, BrTaken, BrRel, Call, Ret;
  logic [D-1:0] BrTarget;
  logic [D-1:0] PrgCtr;
  logic         InstValid, Busy, Done, StackErr;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.D(D), .START_ADDR(12'h000), .STK_DEPTH(STK)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Stall(Stall), .Halt(Halt),
    .BrTaken(BrTaken), .BrRel(BrRel), .BrTarget(BrTarget), .Call(Call), .Ret(Ret),
    .PrgCtr(PrgCtr), .InstValid(InstValid), .Busy(Busy), .Done(Done), .StackErr(StackErr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 running, 2 finished.
  int mode, m_pc, soff;
  bit m_err;
  int m_stk[$];

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mode = 0; m_pc = 0; m_err = 0; m_stk.delete();
    end else if (mode != 1) begin
      if (Start) begin
        mode = 1; m_pc = 0;
        if (mode == 1) begin m_err = 0; m_stk.delete(); end
      end
    end else if (!Stall) begin
      soff = int'(BrTarget) - (BrTarget[D-1] ? DEPTH : 0);
      if (Halt) mode = 2;
`ifdef FETCH_CTRL_RET_STACK_EN
      else if (Ret) begin
        if (m_stk.size() == 0) begin m_pc = (m_pc + 1) % DEPTH; m_err = 1; end
        else m_pc = m_stk.pop_back();
      end
`endif
      else if (BrTaken || Call) begin
`ifdef FETCH_CTRL_RET_STACK_EN
        if (Call) begin
          if (m_stk.size() < STK) m_stk.push_back((m_pc + 1) % DEPTH);
          else m_err = 1;
        end
`endif
        m_pc = BrRel ? (m_pc + soff + DEPTH) % DEPTH : int'(BrTarget);
      end else m_pc = (m_pc + 1) % DEPTH;
    end
  end

  always @(negedge Clk) begin
    check("cyc_pc",    PrgCtr,    m_pc);
    check("cyc_valid", InstValid, (mode == 1) && !Stall);
    check("cyc_busy",  Busy,      mode == 1);
    check("cyc_done",  Done,      mode == 2);
    check("cyc_err",   StackErr,  m_err);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic idle_inputs();
    Start = 0; Stall = 0; Halt = 0; BrTaken = 0; BrRel = 0; Call = 0; Ret = 0;
    BrTarget = '0;
  endtask

  initial begin
    Rst_n = 0;
    idle_inputs();
    tick(2);
    check("rst_pc", PrgCtr, 12'h000);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_valid", InstValid, 0);
    check("rst_err", StackErr, 0);
    Rst_n = 1;
    tick(1);

    // Sequential run and halt at 3
    Start = 1; tick(1); Start = 0;
    check("start_pc", PrgCtr, 12'h000);
    check("start_valid", InstValid, 1);
    tick(3);
    check("seq_pc3", PrgCtr, 12'h003);
    Halt = 1; tick(1); Halt = 0;
    check("halt_done", Done, 1);
    check("halt_busy", Busy, 0);
    check("halt_pc", PrgCtr, 12'h003);
    tick(2);
    check("halt_hold", PrgCtr, 12'h003);

    // Absolute then backward relative branch
    Start = 1; tick(1); Start = 0;
    check("restart_done", Done, 0);
    tick(5);
    check("seq_pc5", PrgCtr, 12'h005);
    BrTaken = 1; BrTarget = 12'h100; tick(1);
    check("br_abs", PrgCtr, 12'h100);
    BrRel = 1; BrTarget = 12'hFFE; tick(1);
    check("br_rel_back", PrgCtr, 12'h0FE);
    BrRel = 0; BrTarget = 12'h007; tick(1); BrTaken = 0;
    check("br_to7", PrgCtr, 12'h007);

    // Stall with concurrent halt
    Stall = 1; Halt = 1; tick(3);
    check("stall_pc", PrgCtr, 12'h007);
    check("stall_valid", InstValid, 0);
    check("stall_done", Done, 0);
    Stall = 0; Halt = 0; tick(1);
    check("after_stall", PrgCtr, 12'h008);

    // Wraparound
    BrTaken = 1; BrTarget = 12'hFFF; tick(1); BrTaken = 0;
    check("pc_max", PrgCtr, 12'hFFF);
    tick(1);
    check("inc_wrap", PrgCtr, 12'h000);
    BrTaken = 1; BrTarget = 12'hFFF; tick(1);
    BrRel = 1; BrTarget = 12'h002; tick(1); BrTaken = 0; BrRel = 0;
    check("rel_wrap", PrgCtr, 12'h001);
    Start = 1; tick(1); Start = 0;
    check("start_in_run", PrgCtr, 12'h002);

    // Call / return
    BrTaken = 1; BrTarget = 12'h010; tick(1); BrTaken = 0;
    Call = 1; BrTarget = 12'h200; tick(1); Call = 0;
    check("call_pc", PrgCtr, 12'h200);
    Ret = 1; tick(1); Ret = 0;
`ifdef FETCH_CTRL_RET_STACK_EN
    check("ret_pc", PrgCtr, 12'h011);
`else
    check("ret_ignored", PrgCtr, 12'h201);
`endif
    Call = 1; BrTarget = 12'h300; tick(5); Call = 0;
    check("nest_pc", PrgCtr, 12'h300);
`ifdef FETCH_CTRL_RET_STACK_EN
    check("overflow_err", StackErr, 1);
`else
    check("no_stack_err", StackErr, 0);
`endif
    Ret = 1; Call = 1; tick(1); Ret = 0; Call = 0;
`ifdef FETCH_CTRL_RET_STACK_EN
    check("ret_beats_call", PrgCtr, 12'h301);
`else
    check("call_as_branch", PrgCtr, 12'h300);
`endif
    Halt = 1; tick(1); Halt = 0;
    Start = 1; tick(1); Start = 0;
    check("restart_err", StackErr, 0);
    Ret = 1; tick(1); Ret = 0;
    check("ret_empty_pc", PrgCtr, 12'h001);
`ifdef FETCH_CTRL_RET_STACK_EN
    check("underflow_err", StackErr, 1);
`endif

    // Reset mid-run
    BrTaken = 1; BrTarget = 12'h040; tick(1); BrTaken = 0;
    check("pre_rst_pc", PrgCtr, 12'h040);
    Rst_n = 0; #1;
    check("midrst_pc", PrgCtr, 12'h000);
    check("midrst_busy", Busy, 0);
    check("midrst_valid", InstValid, 0);
    check("midrst_done", Done, 0);
    check("midrst_err", StackErr, 0);
    tick(1); Rst_n = 1; tick(1);
    check("post_rst_idle", Busy, 0);
    Start = 1; tick(1); Start = 0;
    check("resume_pc0", PrgCtr, 12'h000);
    tick(1);
    check("resume_pc1", PrgCtr, 12'h001);
    Halt = 1; tick(1); Halt = 0;
    check("final_done", Done, 1);
    tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
